// File: rtl/piano_pkg.sv
// Shared piano-voice definitions: note codes, scheduler states and the key-to-note mapping.
package piano_pkg;

  localparam logic [3:0]  NOTE_SILENT = 4'hF;
  localparam int unsigned NUM_NOTES   = 12;
  localparam logic [3:0]  LAST_NOTE   = 4'(NUM_NOTES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StAdvance
  } arp_state_e;

  // Key pins are wired highest bit first: keys[11-n] requests note n.
  function automatic logic [NUM_NOTES-1:0] keys_to_notes(input logic [NUM_NOTES-1:0] keys);
    logic [NUM_NOTES-1:0] notes;
    for (int n = 0; n < NUM_NOTES; n++) begin
      notes[n] = keys[NUM_NOTES-1-n];
    end
    return notes;
  endfunction

endpackage

// File: rtl/rr_next_key.sv
// Wrapping search for the first held note strictly after cur_i; cur_i = 11 yields the lowest.
module rr_next_key
  import piano_pkg::*;
(
  input  logic [NUM_NOTES-1:0] held_i,
  input  logic [3:0]           cur_i,
  output logic [3:0]           next_o,
  output logic                 found_o
);

  logic [3:0] start;
  logic [4:0] idx;

  assign start = (cur_i > LAST_NOTE) ? LAST_NOTE : cur_i;

  always_comb begin
    next_o  = start;
    found_o = 1'b0;
    idx     = '0;
    // Walk farthest offset first so the nearest held note after start wins.
    for (int off = NUM_NOTES; off >= 1; off--) begin
      idx = {1'b0, start} + 5'(off);
      if (idx >= 5'(NUM_NOTES)) begin
        idx = idx - 5'(NUM_NOTES);
      end
      if (held_i[idx[3:0]]) begin
        next_o  = idx[3:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_arpeggiator.sv
// Voice scheduler: mono priority pick or arpeggio rotation over every held key.
module key_arpeggiator
  import piano_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 12,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [NUM_KEYS-1:0]    keys,
  input  logic [3:0]             octave_in,
  input  logic                   mode,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [3:0]             note,
  output logic [3:0]             octave,
  output logic                   gate,
  output logic                   step_pulse
);

  logic [NUM_KEYS-1:0]    ks1_q, ks2_q;
  logic [NUM_NOTES-1:0]   held;
  arp_state_e             state_q, state_d;
  logic [3:0]             note_q, note_d;
  logic [3:0]             octave_q, octave_d;
  logic                   gate_q, gate_d;
  logic                   step_q, step_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d, cnt_load;
  logic [3:0]             rr_cur, rr_next;
  logic                   rr_found, cur_held;

  assign held     = keys_to_notes(ks2_q);
  assign cnt_load = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
  assign cur_held = (note_q <= LAST_NOTE) && held[note_q];
  // Only an arpeggio advance searches from the current note; every other pick wants the lowest.
  assign rr_cur   = (state_q == StAdvance && mode) ? note_q : LAST_NOTE;

  rr_next_key u_rr (
    .held_i  (held),
    .cur_i   (rr_cur),
    .next_o  (rr_next),
    .found_o (rr_found)
  );

  always_comb begin
    state_d  = state_q;
    note_d   = note_q;
    octave_d = octave_q;
    gate_d   = gate_q;
    step_d   = 1'b0;
    cnt_d    = cnt_q;
    if (!ena || !rr_found) begin
      state_d = StIdle;
      note_d  = NOTE_SILENT;
      gate_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StAdvance: begin
          state_d  = StPlay;
          note_d   = rr_next;
          octave_d = octave_in;
          gate_d   = 1'b1;
          step_d   = 1'b1;
          cnt_d    = cnt_load;
        end
        StPlay: begin
          if (!mode) begin
            // Keep the counter primed so a switch to arpeggio starts a full step.
            cnt_d = cnt_load;
            if (rr_next != note_q) begin
              note_d   = rr_next;
              octave_d = octave_in;
              step_d   = 1'b1;
            end
          end else if (!cur_held || cnt_q == '0) begin
            state_d = StAdvance;
          end else begin
            cnt_d = cnt_q - DWELL_WIDTH'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // The synchronizer ignores ena so key state is current when the block is re-enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks1_q <= '0;
      ks2_q <= '0;
    end else begin
      ks1_q <= keys;
      ks2_q <= ks1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      note_q   <= NOTE_SILENT;
      octave_q <= 4'h0;
      gate_q   <= 1'b0;
      step_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      octave_q <= octave_d;
      gate_q   <= gate_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
    end
  end

  assign note       = note_q;
  assign octave     = octave_q;
  assign gate       = gate_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_key_arpeggiator.sv
// Randomized bench for key_arpeggiator against a step-level model, plus literal directed checks.
module tb_key_arpeggiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b1;
  logic [11:0] keys = '0;
  logic [3:0]  octave_in = '0;
  logic        mode = 1'b0;
  logic [15:0] dwell = 16'd4;
  logic [3:0]  note;
  logic [3:0]  octave;
  logic        gate;
  logic        step_pulse;

  int checks = 0;
  int failures = 0;

  key_arpeggiator #(
    .NUM_KEYS    (12),
    .DWELL_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .keys       (keys),
    .octave_in  (octave_in),
    .mode       (mode),
    .dwell      (dwell),
    .note       (note),
    .octave     (octave),
    .gate       (gate),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [11:0] s1 = '0, s2 = '0;   // pin history as seen by the scheduler
  int  m_note = -1;                // -1 = silent
  int  m_oct = 0;
  int  m_elapsed = 0;              // PLAY cycles spent on the current note
  int  m_len = 1;                  // PLAY cycles allowed for the current note
  bit  m_gate = 1'b0;
  bit  m_step = 1'b0;
  bit  m_pend = 1'b0;              // a new selection happens at the next edge
  bit  cmp_en = 1'b0;

  function automatic logic [11:0] notes_of(input logic [11:0] k);
    logic [11:0] r;
    for (int n = 0; n < 12; n++) r[n] = k[11-n];
    return r;
  endfunction

  function automatic int next_after(input logic [11:0] h, input int cur);
    int res;
    bit got;
    res = -1;
    got = 1'b0;
    for (int off = 1; off <= 12; off++) begin
      if (!got && h[(cur + off) % 12]) begin
        res = (cur + off) % 12;
        got = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic model_select(input int n, input int d);
    m_note    = n;
    m_oct     = int'(octave_in);
    m_gate    = 1'b1;
    m_step    = 1'b1;
    m_elapsed = 0;
    m_len     = d;
  endtask

  task automatic model_edge();
    logic [11:0] h;
    int lo;
    int d;
    h  = notes_of(s2);
    d  = (dwell == 16'd0) ? 1 : int'(dwell);
    lo = next_after(h, 11);
    m_step = 1'b0;
    if (!ena || h == 12'd0) begin
      m_note = -1;
      m_gate = 1'b0;
      m_pend = 1'b0;
      m_elapsed = 0;
    end else if (m_note < 0) begin
      model_select(lo, d);
    end else if (m_pend) begin
      m_pend = 1'b0;
      model_select(mode ? next_after(h, m_note) : lo, d);
    end else if (!mode) begin
      m_elapsed = 0;
      m_len = d;
      if (lo != m_note) model_select(lo, d);
    end else if (!h[m_note] || m_elapsed + 1 >= m_len) begin
      m_pend = 1'b1;
    end else begin
      m_elapsed++;
    end
    s2 = s1;
    s1 = keys;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        s1 = '0; s2 = '0; m_note = -1; m_oct = 0; m_gate = 1'b0;
        m_step = 1'b0; m_pend = 1'b0; m_elapsed = 0; m_len = 1;
      end else begin
        model_edge();
      end
    end
  end

  // Per-cycle comparison against the model.
  logic [3:0] exp_note;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        exp_note = (m_note < 0) ? 4'hF : 4'(m_note);
        checks++;
        if (note !== exp_note || octave !== 4'(m_oct) || gate !== m_gate ||
            step_pulse !== m_step) begin
          failures++;
          $display("FAIL model_cycle t=%0t note=%h exp=%h octave=%h exp=%h gate=%b exp=%b step=%b exp=%b",
                   $time, note, exp_note, octave, 4'(m_oct), gate, m_gate, step_pulse, m_step);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_pulse && n < 40);
  endtask

  task automatic go_idle();
    keys = '0;
    tick(4);
  endtask

  int n;
  int exp_seq[3] = '{11, 0, 4};
  int r;

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    #1;
    check_eq("reset_note", int'(note), 15);
    check_eq("reset_gate", int'(gate), 0);
    check_eq("reset_step", int'(step_pulse), 0);
    cmp_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_eq("idle_after_reset", int'(note), 15);

    // Mono priority
    mode = 1'b0;
    keys = 12'h801;
    tick(3);
    check_eq("mono_first_note", int'(note), 0);
    check_eq("mono_first_gate", int'(gate), 1);
    keys = 12'h001;
    tick(3);
    check_eq("mono_release_note", int'(note), 11);
    check_eq("mono_release_pulse", int'(step_pulse), 1);
    go_idle();

    // Arpeggio cycle 0,4,11,0,4 with dwell 4
    mode = 1'b1;
    dwell = 16'd4;
    octave_in = 4'd3;
    keys = 12'h881;
    tick(3);
    check_eq("arp_first_note", int'(note), 0);
    check_eq("arp_first_oct", int'(octave), 3);
    octave_in = 4'd5;
    tick(1);
    check_eq("arp_oct_hold", int'(octave), 3);
    wait_pulse(n);
    check_eq("arp_len_0", n, 4);
    check_eq("arp_note_4", int'(note), 4);
    check_eq("arp_oct_step", int'(octave), 5);
    for (int i = 0; i < 3; i++) begin
      wait_pulse(n);
      check_eq("arp_len", n, 5);
      check_eq("arp_note", int'(note), exp_seq[i]);
    end

    // Asynchronous reset mid-play
    #2 rst_n = 1'b0;
    #1;
    check_eq("midplay_reset_note", int'(note), 15);
    check_eq("midplay_reset_gate", int'(gate), 0);
    check_eq("midplay_reset_step", int'(step_pulse), 0);
    @(negedge clk);
    keys = '0;
    rst_n = 1'b1;
    tick(4);
    check_eq("post_reset_idle_note", int'(note), 15);
    check_eq("post_reset_idle_gate", int'(gate), 0);

    // Release of current note mid-dwell
    dwell = 16'd100;
    keys = 12'h880;
    tick(3);
    check_eq("release_first_note", int'(note), 0);
    tick(9);
    keys = 12'h080;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (note != 4'd4 && n < 10);
    check_eq("release_latency", n, 4);
    check_eq("release_pulse", int'(step_pulse), 1);
    go_idle();

    // dwell 0 behaves as 1, single key
    dwell = 16'd0;
    keys = 12'h010;
    tick(3);
    check_eq("single_note", int'(note), 7);
    for (int i = 0; i < 3; i++) begin
      wait_pulse(n);
      check_eq("single_len", n, 2);
      check_eq("single_note_hold", int'(note), 7);
    end
    go_idle();

    // Wrap 11 -> 2
    dwell = 16'd2;
    keys = 12'h201;
    tick(3);
    check_eq("wrap_first", int'(note), 2);
    wait_pulse(n);
    check_eq("wrap_len_a", n, 3);
    check_eq("wrap_note_11", int'(note), 11);
    wait_pulse(n);
    check_eq("wrap_len_b", n, 3);
    check_eq("wrap_note_2", int'(note), 2);

    // ena drop and re-raise
    tick(1);
    ena = 1'b0;
    tick(1);
    check_eq("ena_low_note", int'(note), 15);
    check_eq("ena_low_gate", int'(gate), 0);
    ena = 1'b1;
    tick(1);
    check_eq("ena_restart_note", int'(note), 2);
    check_eq("ena_restart_pulse", int'(step_pulse), 1);

    // Randomized traffic, checked by the per-cycle model comparison
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      if (r < 4) keys = 12'($urandom);
      else if (r < 6) keys = '0;
      else if (r < 10) keys = keys ^ 12'(12'd1 << $urandom_range(0, 11));
      if ($urandom_range(0, 19) == 0) dwell = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) octave_in = 4'($urandom);
      if ($urandom_range(0, 149) == 0) mode = ~mode;
      ena = ($urandom_range(0, 99) != 0);
    end
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
